// File: rtl/onehot_req_capture.sv
// onehot_req_capture: synchronises and debounces four request lines, queues
// their rising edges and presents them one at a time as a held one-hot
// vector (y3 highest priority) with a valid/ack handshake.

// Per-line front end: 2-flop synchroniser, debounce counter, rise detect.
module onehot_req_capture_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  localparam logic [CNT_W:0] D_L = (CNT_W+1)'(DEBOUNCE_CYCLES);

  logic             s1, s2;
  logic             deb, deb_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_nx;

  // Counter stays one bit wider in the compare so D = 2^CNT_W is reachable.
  assign cnt_nx = {1'b0, cnt} + (CNT_W+1)'(1);

  // Synchronise, then accept a level change after D consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      deb_d <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt_nx == D_L) begin
        deb <= ~deb;
        cnt <= '0;
      end else begin
        cnt <= cnt_nx[CNT_W-1:0];
      end
    end
  end

  // Only the debounced 0->1 transition is a request; release is ignored.
  assign rise = deb & ~deb_d;
endmodule

module onehot_req_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       ack,
  output logic       y0,
  output logic       y1,
  output logic       y2,
  output logic       y3,
  output logic       valid,
  output logic [3:0] pending,
  output logic       overflow
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0] state;
  logic [3:0] rise;
  logic [3:0] sel;
  logic [3:0] clear;
  logic [3:0] y;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    onehot_req_capture_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .btn (btn[i]),
      .rise(rise[i])
    );
  end

  // Highest pending index wins, matching the downstream encoder's code order.
  always_comb begin
    sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (pending[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  // A pending bit is consumed only when it is launched from IDLE.
  assign clear = (state == IDLE) ? sel : 4'b0000;

  // Pending queue, sticky overflow, and the present/ack handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      y        <= '0;
      valid    <= 1'b0;
    end else begin
      // Set beats a same-edge clear; a rise on a still-pending line is lost.
      pending <= (pending & ~clear) | rise;
      if (|(rise & pending & ~clear))
        overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (|pending) begin
            y     <= sel;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            y     <= '0;
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          y     <= '0;
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign y0 = y[0];
  assign y1 = y[1];
  assign y2 = y[2];
  assign y3 = y[3];
endmodule

// File: tb/tb_onehot_req_capture.sv
// Self-checking bench for onehot_req_capture: directed scenarios plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_onehot_req_capture;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, ack;
  logic [3:0] btn;
  logic       y0, y1, y2, y3, valid, overflow;
  logic [3:0] pending;

  onehot_req_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn(btn), .ack(ack),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .valid(valid), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit [3:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_pend, m_y;
  bit       m_valid, m_ovf;
  int       m_run [4];

  bit       prev_v;
  int       pres_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, from values before the edge.
  task automatic model_edge();
    bit [3:0] rise_v, take;
    int       k;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvl_prev = 0; m_pend = 0;
      m_y = 0; m_valid = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      return;
    end
    rise_v = m_lvl & ~m_lvl_prev;
    m_lvl_prev = m_lvl;
    // level accepted once D consecutive synchronised samples disagree with it
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] == m_lvl[i]) m_run[i] = 0;
      else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
    take = 0;
    if (!m_valid) begin
      k = -1;
      for (int i = 3; i >= 0; i--) if (m_pend[i] && k < 0) k = i;
      if (k >= 0) begin
        take[k] = 1;
        m_y = 0; m_y[k] = 1;
        m_valid = 1;
      end
    end else if (ack) begin
      m_y = 0;
      m_valid = 0;
    end
    if ((rise_v & m_pend & ~take) != 0) m_ovf = 1;
    m_pend = (m_pend & ~take) | rise_v;
  endtask

  task automatic step();
    logic [3:0] yv;
    @(posedge clk);
    model_edge();
    #1;
    yv = {y3, y2, y1, y0};
    chk("y", yv, m_y);
    chk("valid", valid, m_valid);
    chk("pending", pending, m_pend);
    chk("overflow", overflow, m_ovf);
    chk("onehot", ($countones(yv) <= 1) && (valid == |yv), 1);
    if (valid && !prev_v) pres_log.push_back(int'(yv));
    prev_v = valid;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    int lat, n_y1, guard;
    rst = 1'b1; btn = 4'b0000; ack = 1'b0; prev_v = 1'b0;
    run(2);
    rst = 1'b0;
    run(20);

    // single press: latency to valid from btn held before edge 1
    btn = 4'b0100;
    lat = 0;
    for (int e = 1; e <= 11; e++) begin
      step();
      if (valid && lat == 0) lat = e;
    end
    chk("latency_edges", lat, 8);
    do_ack();
    chk("single_ack_valid", valid, 0);
    btn = 4'b0000;
    run(10);

    // simultaneous press, ack the cycle after each valid
    pres_log.delete();
    btn = 4'b1011;
    guard = 0;
    while ((pres_log.size() < 3 || valid) && guard < 200) begin
      ack = valid && !ack;
      step();
      guard++;
    end
    ack = 1'b0;
    chk("simul_timeout", guard < 200, 1);
    chk("simul_count", pres_log.size(), 3);
    if (pres_log.size() == 3) begin
      chk("simul_first", pres_log[0], 8);
      chk("simul_second", pres_log[1], 2);
      chk("simul_third", pres_log[2], 1);
    end
    btn = 4'b0000;
    run(10);

    // glitch of D-1 samples rejected, D samples accepted
    pres_log.delete();
    btn = 4'b0001; run(D - 1); btn = 4'b0000; run(15);
    chk("glitch_reject", pres_log.size(), 0);
    btn = 4'b0001; run(D); btn = 4'b0000; run(15);
    chk("glitch_accept", pres_log.size(), 1);
    chk("glitch_y0", {y3, y2, y1, y0}, 4'b0001);
    do_ack();
    run(5);

    // overflow: second press on line 1 while it is still pending
    pres_log.delete();
    btn = 4'b1000; run(10);
    btn = 4'b1010; run(10);
    btn = 4'b1000; run(10);
    btn = 4'b1010; run(10);
    chk("ovf_set", overflow, 1);
    chk("ovf_pending", pending, 4'b0010);
    btn = 4'b0000;
    do_ack(); run(10);
    do_ack(); run(10);
    n_y1 = 0;
    foreach (pres_log[i]) if (pres_log[i] == 2) n_y1++;
    chk("ovf_single_y1", n_y1, 1);
    chk("ovf_sticky", overflow, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("ovf_rst_clear", overflow, 0);

    // reset mid-presentation drops everything
    btn = 4'b1101; run(12);
    chk("mid_valid", valid, 1);
    chk("mid_pending", pending, 4'b0101);
    btn = 4'b0000; rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_pending", pending, 0);
    pres_log.delete();
    run(20);
    chk("mid_no_resume", pres_log.size(), 0);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) btn[$urandom_range(3)] ^= 1'b1;
      ack = ($urandom_range(2) == 0);
      rst = ($urandom_range(399) == 0);
      step();
    end
    rst = 1'b0; ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/onehot_req_capture.md
Name: onehot_req_capture

Overview:
- Input stage directly upstream of the 4-to-2 encoder.
- Takes four raw request/button lines and synchronises and debounces each one.
- Latches rising edges as pending requests and presents them one at a time as a held one-hot vector on y0..y3 with a valid/ack handshake.
- Encoder stage consumes y0..y3. Priority is y3 > y2 > y1 > y0, matching the encoder's code order, so each presented vector is exactly one-hot and encodes unambiguously.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive differing synchronised samples required to accept a level change (legal range 1..2^CNT_W).
- CNT_W, 3, width of each per-line debounce counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn  input  4  raw asynchronous request lines; bit i maps to y_i.
- ack  input  1  downstream consumed the presented code.
- y0  output  1  one-hot request bit 0 (held while valid).
- y1  output  1  one-hot request bit 1.
- y2  output  1  one-hot request bit 2.
- y3  output  1  one-hot request bit 3.
- valid  output  1  y0..y3 carries a request.
- pending  output  4  queued, not-yet-presented requests.
- overflow  output  1  sticky: a rise occurred on an already-pending line.

Behaviour:
- Reset (rst=1 at an edge): all synchroniser flops 0, debounced levels 0, counters 0, pending 0, FSM IDLE, y0..y3 0, valid 0, overflow 0. Reset overrides all other events, including mid-presentation; an in-flight request is dropped.
- Synchroniser: 2-flop per line, sync = second flop.
- Debounce, per line i:
  - If sync[i] == deb[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments. On the edge where the differing sample count reaches DEBOUNCE_CYCLES, deb[i] toggles and cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised samples leaves deb unchanged.
- Edge detect: rise[i] = deb[i] & ~deb_d[i]. Only 0->1 generates a request; release is ignored.
- Pending:
  - rise[i] sets pending[i].
  - Bit i clears only when selected for presentation.
  - If rise[i] and clear[i] occur on the same edge, set wins and overflow is not flagged.
  - If rise[i] occurs while pending[i] is already 1 (and not clearing), the request is dropped and overflow <= 1 (sticky until rst).
- FSM states:
  - IDLE (valid=0, y=0): if pending != 0, select the highest set index k; on the same edge y_k <= 1, others 0, valid <= 1, pending[k] <= 0, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: hold y and valid stable regardless of btn activity. When ack=1 at an edge: y <= 0, valid <= 0, go to IDLE.
  - ack in IDLE is ignored.
  - At least one idle cycle (valid=0) separates consecutive presentations.
- Rises during PRESENT, including on the line being presented, queue into pending normally.
- Latency: with btn going high and held from before edge 1 (D = DEBOUNCE_CYCLES):
  - sync high after edge 2.
  - deb high after edge 2+D.
  - pending high after edge 3+D.
  - valid high after edge 4+D, which is edge 8 for D=4.
- Invariant: at most one of y0..y3 is 1 at any time; valid == (y0|y1|y2|y3).

Test Plan:
- Reset then idle: rst for 2 cycles, btn=0000 -> y=0000, valid=0, pending=0000, overflow=0 for 20 cycles.
- Single press: btn=0100 held from cycle 0, D=4 -> pending=0100 after edge 7; valid=1, y2=1 after edge 8 with pending=0000. Hold until ack=1 at edge 12 -> valid=0 after edge 12.
- Simultaneous press: btn=1011 at once, ack pulsed one cycle after each valid:
  - y3 presented first, then y1, then y0, with a valid=0 gap between each.
  - pending sequence 1011 -> 0011 -> 0001 -> 0000.
- Glitch rejection: btn[0] high for 3 synchronised cycles then low, D=4 -> deb, pending and valid never change. Repeat with 4 cycles -> request on y0 presented.
- Overflow: press btn[1], release, press again (each debounced) while y3 is being presented and pending[1]=1 -> overflow=1 stays set, pending=0010, and only one y1 presentation follows. Then rst clears overflow.
- Reset mid-operation: rst asserted while valid=1 and pending=0101 -> after that edge valid=0, y=0000, pending=0000. No presentation resumes without new presses.
